// File: rtl/mux21_rr_arb.sv
// Two-requester round-robin arbiter that drives a shared 2:1 data mux.
// One requester owns the output at a time. Ownership passes to the other
// requester when the owner stops requesting, or when the owner has used up
// its burst allowance (HOLD_MAX transfers) while the other side is waiting.
// The mux select is a registered copy of the ownership state. The data
// path, valid and grant strobes are combinational from that state.

module mux21_rr_arb #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] inp0,
    input  logic [WIDTH-1:0] inp1,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outp,
    output logic             out_valid,
    output logic             sel,
    output logic             gnt0,
    output logic             gnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    // Burst limit as a 4-bit constant that matches the counter width.
    localparam logic [3:0] HOLD_C = 4'(HOLD_MAX);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;   // requester index that last took ownership
    logic       sel_q, sel_d;

    logic       own_req_s;        // the current owner is still requesting
    logic       oth_req_s;        // the non-owner is requesting
    logic       xfer_s;           // a word moves downstream this cycle
    logic [3:0] cnt_inc_s;        // counter after one transfer, saturated
    logic [3:0] cnt_adv_s;        // counter after this cycle's activity

    // Select which request belongs to the owner and which to the other side.
    always_comb begin
        own_req_s = 1'b0;
        oth_req_s = 1'b0;
        case (state_q)
            OWN0: begin
                own_req_s = req0;
                oth_req_s = req1;
            end
            OWN1: begin
                own_req_s = req1;
                oth_req_s = req0;
            end
            default: begin
                own_req_s = 1'b0;
                oth_req_s = 1'b0;
            end
        endcase
    end

    // Shared data path, valid and grant strobes, all derived from the state.
    always_comb begin
        outp      = sel_q ? inp1 : inp0;
        out_valid = ((state_q == OWN0) & req0) | ((state_q == OWN1) & req1);
        xfer_s    = out_valid & out_ready;
        gnt0      = xfer_s & (state_q == OWN0);
        gnt1      = xfer_s & (state_q == OWN1);
        sel       = sel_q;
    end

    // Burst counter advance. The counter saturates at the hold limit.
    always_comb begin
        if (cnt_q >= HOLD_C) begin
            cnt_inc_s = HOLD_C;
        end else begin
            cnt_inc_s = cnt_q + 4'd1;
        end
        if (xfer_s) begin
            cnt_adv_s = cnt_inc_s;
        end else begin
            cnt_adv_s = cnt_q;
        end
    end

    // Next ownership, burst count and last-owner bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // When both request, the side that did not own last time wins.
                if (req0 & req1) begin
                    if (last_q) begin
                        state_d = OWN0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = OWN1;
                        last_d  = 1'b1;
                    end
                    cnt_d = 4'd0;
                end else if (req0) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                    cnt_d   = 4'd0;
                end else if (req1) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            OWN0, OWN1: begin
                if (!own_req_s) begin
                    // The owner released the output. Hand over, or go idle.
                    if (oth_req_s) begin
                        state_d = (state_q == OWN0) ? OWN1 : OWN0;
                        last_d  = (state_q == OWN0) ? 1'b1 : 1'b0;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end else if (xfer_s && (cnt_adv_s == HOLD_C) && oth_req_s) begin
                    // The burst allowance is used up and the other side waits.
                    state_d = (state_q == OWN0) ? OWN1 : OWN0;
                    last_d  = (state_q == OWN0) ? 1'b1 : 1'b0;
                    cnt_d   = 4'd0;
                end else begin
                    // Keep ownership. A stall leaves the counter unchanged.
                    state_d = state_q;
                    cnt_d   = cnt_adv_s;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                last_d  = 1'b1;
            end
        endcase
    end

    // The select follows the next state, so it registers together with it.
    always_comb begin
        if (state_d == OWN1) begin
            sel_d = 1'b1;
        end else begin
            sel_d = 1'b0;
        end
    end

    // Arbiter state register. last_q resets to 1 so that requester 0 wins
    // the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    mux21_rr_arb_chk #(
        .HOLD_MAX (HOLD_MAX)
    ) u_chk (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .gnt0_i      (gnt0),
        .gnt1_i      (gnt1),
        .sel_i       (sel_q),
        .out_valid_i (out_valid),
        .state_i     (state_q),
        .cnt_i       (cnt_q)
    );

endmodule

// Invariant checker for the arbiter. It only observes and drives nothing.
module mux21_rr_arb_chk #(
    parameter int HOLD_MAX = 4
) (
    input logic       clk_i,
    input logic       rst_n_i,
    input logic       gnt0_i,
    input logic       gnt1_i,
    input logic       sel_i,
    input logic       out_valid_i,
    input logic [1:0] state_i,
    input logic [3:0] cnt_i
);

    localparam logic [3:0] HOLD_C = 4'(HOLD_MAX);

    a_hold_range: assert property (@(posedge clk_i)
        (HOLD_MAX >= 1) && (HOLD_MAX <= 15));

    a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(gnt0_i && gnt1_i));

    a_grant_valid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (gnt0_i || gnt1_i) |-> out_valid_i);

    a_cnt_sat: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        cnt_i <= HOLD_C);

    a_sel_state: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        sel_i == (state_i == 2'd2));

    a_state_legal: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        state_i != 2'd3);

endmodule

// File: tb/tb_mux21_rr_arb.sv
// Bench for mux21_rr_arb. It drives two instances from the same inputs,
// with hold limits 4 and 1. A behavioural ownership model predicts every
// output on every cycle. Directed sequences pin the model against
// hand-derived literals, and randomized traffic with mid-cycle resets follows.

module tb_mux21_rr_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0, req1, out_ready;
    logic [7:0] inp0, inp1;

    logic [7:0] d_outp [2];
    logic [1:0] d_valid, d_sel, d_g0, d_g1;

    int checks = 0;
    int errors = 0;

    // Model state per instance: owner 0 = none, 1 = requester 0, 2 = requester 1.
    int m_own  [2] = '{0, 0};
    int m_cnt  [2] = '{0, 0};
    int m_last [2] = '{1, 1};
    int hold_c [2] = '{4, 1};

    logic [15:0] ha_g0, ha_g1, hb_g0, hb_g1;
    logic        nd0, nd1;

    always #5 clk = ~clk;

    mux21_rr_arb #(.WIDTH(8), .HOLD_MAX(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .inp0(inp0), .inp1(inp1), .out_ready(out_ready),
        .outp(d_outp[0]), .out_valid(d_valid[0]), .sel(d_sel[0]),
        .gnt0(d_g0[0]), .gnt1(d_g1[0])
    );

    mux21_rr_arb #(.WIDTH(8), .HOLD_MAX(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .inp0(inp0), .inp1(inp1), .out_ready(out_ready),
        .outp(d_outp[1]), .out_valid(d_valid[1]), .sel(d_sel[1]),
        .gnt0(d_g0[1]), .gnt1(d_g1[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic mine_req(input int own, input logic r0, input logic r1);
        return (own == 1) ? r0 : r1;
    endfunction

    function automatic logic other_req(input int own, input logic r0, input logic r1);
        return (own == 1) ? r1 : r0;
    endfunction

    function automatic int sat_inc(input int c, input int h);
        return (c + 1 > h) ? h : c + 1;
    endfunction

    // Ownership model, advanced from the inputs present at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_own[i]  <= 0;
                m_cnt[i]  <= 0;
                m_last[i] <= 1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_own[i] == 0) begin
                    if (req0 && req1) begin
                        m_own[i]  <= (m_last[i] == 1) ? 1 : 2;
                        m_last[i] <= (m_last[i] == 1) ? 0 : 1;
                        m_cnt[i]  <= 0;
                    end else if (req0) begin
                        m_own[i] <= 1; m_last[i] <= 0; m_cnt[i] <= 0;
                    end else if (req1) begin
                        m_own[i] <= 2; m_last[i] <= 1; m_cnt[i] <= 0;
                    end
                end else if (!mine_req(m_own[i], req0, req1)) begin
                    if (other_req(m_own[i], req0, req1)) begin
                        m_own[i]  <= 3 - m_own[i];
                        m_last[i] <= 2 - m_own[i];
                        m_cnt[i]  <= 0;
                    end else begin
                        m_own[i] <= 0;
                        m_cnt[i] <= 0;
                    end
                end else if (out_ready) begin
                    if (sat_inc(m_cnt[i], hold_c[i]) == hold_c[i] &&
                        other_req(m_own[i], req0, req1)) begin
                        m_own[i]  <= 3 - m_own[i];
                        m_last[i] <= 2 - m_own[i];
                        m_cnt[i]  <= 0;
                    end else begin
                        m_cnt[i] <= sat_inc(m_cnt[i], hold_c[i]);
                    end
                end
            end
        end
    end

    // Compare every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk((i == 0) ? "valid_h4" : "valid_h1", {31'd0, d_valid[i]},
                    {31'd0, (m_own[i] == 1 && req0) || (m_own[i] == 2 && req1)});
                chk((i == 0) ? "sel_h4" : "sel_h1", {31'd0, d_sel[i]},
                    {31'd0, m_own[i] == 2});
                chk((i == 0) ? "outp_h4" : "outp_h1", {24'd0, d_outp[i]},
                    {24'd0, (m_own[i] == 2) ? inp1 : inp0});
                chk((i == 0) ? "gnt0_h4" : "gnt0_h1", {31'd0, d_g0[i]},
                    {31'd0, m_own[i] == 1 && req0 && out_ready});
                chk((i == 0) ? "gnt1_h4" : "gnt1_h1", {31'd0, d_g1[i]},
                    {31'd0, m_own[i] == 2 && req1 && out_ready});
            end
        end
    end

    task automatic drive(input logic r0, input logic r1, input logic [7:0] a,
                         input logic [7:0] b, input logic rdy);
        @(posedge clk);
        #1;
        req0 = r0; req1 = r1; inp0 = a; inp1 = b; out_ready = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        req0 = 1'b0; req1 = 1'b0; inp0 = 8'h3C; inp1 = 8'hC3; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sel",   {31'd0, d_sel[0]},   32'd0);
        chk("rst_valid", {31'd0, d_valid[0]}, 32'd0);
        chk("rst_gnt0",  {31'd0, d_g0[0]},    32'd0);
        chk("rst_gnt1",  {31'd0, d_g1[0]},    32'd0);
        chk("rst_outp",  {24'd0, d_outp[0]},  32'h3C);

        // Single requester 0: one idle arbitration cycle, then continuous grants.
        do_reset();
        drive(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
        @(negedge clk);
        chk("idle_valid", {31'd0, d_valid[0]}, 32'd0);
        chk("idle_gnt0",  {31'd0, d_g0[0]},    32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);
            @(negedge clk);
            chk("own0_valid", {31'd0, d_valid[0]}, 32'd1);
            chk("own0_outp",  {24'd0, d_outp[0]},  32'hA5);
            chk("own0_gnt0",  {31'd0, d_g0[0]},    32'd1);
        end

        // Both requesting: bursts of 4 (limit 4) and of 1 (limit 1) alternate.
        do_reset();
        drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
        ha_g0 = '0; ha_g1 = '0; hb_g0 = '0; hb_g1 = '0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
            @(negedge clk);
            ha_g0 = {ha_g0[14:0], d_g0[0]};
            ha_g1 = {ha_g1[14:0], d_g1[0]};
            hb_g0 = {hb_g0[14:0], d_g0[1]};
            hb_g1 = {hb_g1[14:0], d_g1[1]};
        end
        chk("burst4_gnt0", {16'd0, ha_g0}, 32'hF0F0);
        chk("burst4_gnt1", {16'd0, ha_g1}, 32'h0F0F);
        chk("burst1_gnt0", {16'd0, hb_g0}, 32'hAAAA);
        chk("burst1_gnt1", {16'd0, hb_g1}, 32'h5555);

        // Stall in OWN1 after 2 transfers: the counter must not move.
        do_reset();
        drive(1'b0, 1'b1, 8'h00, 8'h5A, 1'b1);
        repeat (2) begin
            drive(1'b0, 1'b1, 8'h00, 8'h5A, 1'b1);
            @(negedge clk);
            chk("own1_gnt1", {31'd0, d_g1[0]}, 32'd1);
        end
        repeat (5) begin
            drive(1'b1, 1'b1, 8'h00, 8'h5A, 1'b0);
            @(negedge clk);
            chk("stall_valid", {31'd0, d_valid[0]}, 32'd1);
            chk("stall_gnt1",  {31'd0, d_g1[0]},    32'd0);
            chk("stall_sel",   {31'd0, d_sel[0]},   32'd1);
        end
        repeat (2) begin
            drive(1'b1, 1'b1, 8'h00, 8'h5A, 1'b1);
            @(negedge clk);
            chk("resume_gnt1", {31'd0, d_g1[0]}, 32'd1);
        end
        drive(1'b1, 1'b1, 8'h00, 8'h5A, 1'b1);
        @(negedge clk);
        chk("after_stall_sel",  {31'd0, d_sel[0]}, 32'd0);
        chk("after_stall_gnt0", {31'd0, d_g0[0]},  32'd1);

        // Owner 0 drops after 2 transfers: requester 1 takes over with a fresh count.
        do_reset();
        drive(1'b1, 1'b0, 8'h31, 8'h00, 1'b1);
        repeat (2) drive(1'b1, 1'b0, 8'h31, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h31, 8'h42, 1'b1);
        @(negedge clk);
        chk("drop_valid", {31'd0, d_valid[0]}, 32'd0);
        repeat (4) begin
            drive(1'b1, 1'b1, 8'h31, 8'h42, 1'b1);
            @(negedge clk);
            chk("handover_sel",  {31'd0, d_sel[0]}, 32'd1);
            chk("handover_gnt1", {31'd0, d_g1[0]},  32'd1);
        end
        drive(1'b1, 1'b1, 8'h31, 8'h42, 1'b1);
        @(negedge clk);
        chk("handover_back", {31'd0, d_g0[0]}, 32'd1);

        // Asynchronous reset mid-burst. Requester 0 must win the first tie afterwards.
        do_reset();
        drive(1'b1, 1'b0, 8'h77, 8'h00, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 8'h77, 8'h00, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, d_valid[0]}, 32'd0);
        chk("arst_gnt0",  {31'd0, d_g0[0]},    32'd0);
        chk("arst_sel",   {31'd0, d_sel[0]},   32'd0);
        chk("arst_outp",  {24'd0, d_outp[0]},  32'h77);
        @(negedge clk);
        #1;
        rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; inp1 = 8'h88;
        drive(1'b1, 1'b1, 8'h77, 8'h88, 1'b1);
        @(negedge clk);
        chk("arst_first_gnt0", {31'd0, d_g0[0]},  32'd1);
        chk("arst_first_sel",  {31'd0, d_sel[0]}, 32'd0);

        // Limit 1 with only requester 1: continuous grants until requester 0 rises.
        do_reset();
        drive(1'b0, 1'b1, 8'h00, 8'h9C, 1'b1);
        repeat (4) begin
            drive(1'b0, 1'b1, 8'h00, 8'h9C, 1'b1);
            @(negedge clk);
            chk("h1_solo_gnt1", {31'd0, d_g1[1]}, 32'd1);
        end
        drive(1'b1, 1'b1, 8'h12, 8'h9C, 1'b1);
        @(negedge clk);
        chk("h1_last_gnt1", {31'd0, d_g1[1]}, 32'd1);
        drive(1'b1, 1'b1, 8'h12, 8'h9C, 1'b1);
        @(negedge clk);
        chk("h1_switch_sel",  {31'd0, d_sel[1]}, 32'd0);
        chk("h1_switch_gnt0", {31'd0, d_g0[1]},  32'd1);

        // Randomized traffic with occasional asynchronous resets mid-cycle.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            nd0 = !req0 || d_g0[0];
            nd1 = !req1 || d_g1[0];
            @(posedge clk);
            #1;
            if (req0) req0 = ($urandom_range(0, 7) != 0);
            else      req0 = ($urandom_range(0, 1) != 0);
            if (req1) req1 = ($urandom_range(0, 7) != 0);
            else      req1 = ($urandom_range(0, 1) != 0);
            if (nd0) inp0 = 8'($urandom);
            if (nd1) inp1 = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                @(negedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
